// File: rtl/excess_enc_pkg.sv
// Shared constants and helpers for the one-hot keypad encoder FIFO.
package excess_enc_pkg;

  localparam logic CODE_BIN  = 1'b0;
  localparam logic CODE_EXN  = 1'b1;
  localparam int   ERR_CNT_W = 8;

  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/onehot_index_enc.sv
// One-hot key vector to index encoder with validity flags.
// Macro ENC_PRIORITY_EN: index resolves to the lowest set bit of a multi-hot vector.
module onehot_index_enc
  import excess_enc_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int IDX_W = 4
) (
  input  logic [IN_W-1:0]  vec,
  output logic [IDX_W-1:0] index,
  output logic             is_onehot,
  output logic             is_zero
);

  always_comb begin
    index = '0;
`ifdef ENC_PRIORITY_EN
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
`else
    // OR of set-bit positions; exact for a true one-hot vector.
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) index = index | IDX_W'(i);
    end
`endif
  end

  assign is_zero   = (vec == '0);
  assign is_onehot = !is_zero && ((vec & (vec - IN_W'(1))) == '0);

endmodule

// File: rtl/excess_n_encoder_fifo.sv
// Registered one-hot to binary/excess-N encoder feeding a small FIFO, with error count.
// Macro ENC_PRIORITY_EN: multi-hot vectors encode their lowest set bit instead of erroring.
module excess_n_encoder_fifo
  import excess_enc_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int OFFSET = 3,
  parameter int OUT_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          code_sel,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          err,
  output logic [ERR_CNT_W-1:0]          err_cnt,
  output logic [occ_width(DEPTH)-1:0]   count
);

  localparam int IDX_W = $clog2(IN_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = occ_width(DEPTH);

`ifdef ENC_PRIORITY_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  logic [IDX_W-1:0] index;
  logic             is_onehot;
  logic             is_zero;
  logic             vec_ok;
  logic             accept;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] code;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  onehot_index_enc #(
    .IN_W  (IN_W),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec       (in_data),
    .index     (index),
    .is_onehot (is_onehot),
    .is_zero   (is_zero)
  );

  assign vec_ok    = is_onehot | (PRIO_EN & ~is_zero);
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign accept    = in_valid && in_ready;
  assign push      = accept && vec_ok;
  assign pop       = out_valid && out_ready;

  // Sum wraps at OUT_W bits when OFFSET pushes past the code range.
  assign code = OUT_W'(index) + ((code_sel == CODE_EXN) ? OUT_W'(OFFSET) : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= code;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      err <= accept && !vec_ok;
      if (accept && !vec_ok && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: doc/excess_n_encoder_fifo.md
Name: excess_n_encoder_fifo

Overview:
Parametrised, registered successor to the combinational one-hot-to-excess-3 keypad encoder. Accepts one-hot key vectors over a valid/ready handshake and checks them for one-hot validity. Valid vectors are encoded to plain binary index or excess-N code and buffered in a small FIFO for a downstream display or serial stage. Invalid vectors are flagged and counted, never encoded.

Parameters:
IN_W, 10, number of one-hot input lines (2..16)
OFFSET, 3, excess-N offset added in excess mode (0..15)
OUT_W, 4, code width; requires IN_W-1+OFFSET < 2**OUT_W
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_data  in  IN_W  one-hot key vector
in_valid  in  1  in_data valid
in_ready  out  1  block can accept
code_sel  in  1  0 = binary index, 1 = index+OFFSET; sampled at accept
out_data  out  OUT_W  code at FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer takes head
err  out  1  one-cycle pulse: accepted vector was invalid
err_cnt  out  8  saturating invalid-vector count
count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, sampled on clk edge with rst_n=0: pointers and count=0, out_valid=0, out_data=0, err=0, err_cnt=0, in_ready=1. Reset mid-operation discards all buffered entries.
- in_ready = (count != DEPTH). No full-bypass: a pop in the same cycle does not make room.
- Accept = in_valid && in_ready.
- Valid vector, exactly one bit set at position k:
  - push k when code_sel=0, k+OFFSET when code_sel=1, truncated to OUT_W.
- Invalid vector, zero bits or more than one bit set:
  - no push
  - err=1 on the next cycle for exactly one cycle
  - err_cnt+1, saturating at 255
- Pop = out_valid && out_ready. out_data is the registered head and holds stable while out_valid=1 and out_ready=0.
- Latency: accept into an empty FIFO gives out_valid=1 and the correct out_data on the next edge.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
- Pop and invalid accept in the same cycle: the pop proceeds, err pulses.
- Pointers wrap modulo DEPTH. Strict FIFO order.
- Behaviour is undefined if in_data changes while in_valid=1 and in_ready=0; the bench must not do this.

Optional Feature:
Macro ENC_PRIORITY_EN.
- Defined: multi-hot vectors encode the lowest set bit and push normally. Only all-zero vectors raise err.
- Undefined: any non-one-hot vector raises err and is dropped.

Decomposition:
- Shared package excess_enc_pkg:
  - code_sel encoding constants CODE_BIN=0 and CODE_EXN=1
  - ERR_CNT_W=8
  - function for occupancy width, clog2(DEPTH)+1
- One sub-module, onehot_index_enc, combinational:
  - outputs index, is_onehot and is_zero for IN_W lines
  - honours ENC_PRIORITY_EN
  - top level holds the FIFO, handshake and error counter.

Test Plan:
1. Defaults, code_sel=1, out_ready=1. in_data=0000000001 gives out_data=0011 one cycle after accept. 1000000000 gives 1100.
2. code_sel=0, in_data=0001000000 gives out_data=0110. Switching code_sel after accept does not change the queued value.
3. in_data=0000000000 gives an err pulse and err_cnt=1 with no push. in_data=0000000011 gives err and err_cnt=2 when ENC_PRIORITY_EN is undefined; when defined it gives out_data=0011 and no err.
4. out_ready=0, push bits 0..3 in excess mode. After the fourth accept count=4 and in_ready=0. A fifth in_valid is held off. Drain order is 0011, 0100, 0101, 0110.
5. count=2, push and pop in the same cycle: count stays 2, the popped value is the oldest entry, and the new entry lands at the tail.
6. count=3, drive rst_n=0 for one edge: next cycle count=0, out_valid=0, in_ready=1, err_cnt=0.
